// File: rtl/mem_arbiter.sv
// Purpose: serialises DCache refill/write-back and ICache refill blocks onto a byte-wide RAM port.
// Latency: refill strobe BLOCK_SIZE+1 cycles after grant, write-back strobe BLOCK_SIZE cycles after grant.
// Backpressure: readyIn=0 freezes all state; clearIn aborts refills; ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_arbiter #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  input  logic                      readyIn,
  input  logic                      clearIn,
  input  logic                      dMiss,
  input  logic [31-BLOCK_WIDTH:0]   dMissAddr,
  input  logic                      dReadWrite,
  input  logic [BLOCK_SIZE*8-1:0]   dWriteBack,
  input  logic                      iMiss,
  input  logic [31-BLOCK_WIDTH:0]   iMissAddr,
  input  logic [7:0]                memDin,
  output logic [7:0]                memDout,
  output logic [31:0]               memA,
  output logic                      memWr,
  output logic [31-BLOCK_WIDTH:0]   memAddr,
  output logic [BLOCK_SIZE*8-1:0]   memData,
  output logic                      dMemDataValid,
  output logic                      dAcceptWrite,
  output logic                      iMemDataValid
);

  localparam int AW = 32 - BLOCK_WIDTH;
  localparam int DW = BLOCK_SIZE * 8;
  localparam int CW = BLOCK_WIDTH + 1;
  localparam logic [CW-1:0] CNT_RD_DONE = CW'(BLOCK_SIZE);
  localparam logic [CW-1:0] CNT_WR_LAST = CW'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            owner_q, owner_d;      // 1 = ICache owns the transfer
  logic [DW-1:0]   wbuf_q, wbuf_d;
  logic [DW-1:0]   rbuf_q, rbuf_d;
  logic [31:0]     mem_a_q, mem_a_d;
  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            mem_wr_q, mem_wr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic            d_vld_q, d_vld_d;
  logic            d_acc_q, d_acc_d;
  logic            i_vld_q, i_vld_d;

  logic                   any_stb;
  logic                   grant_ok;
  logic                   gnt_d;
  logic                   gnt_i;
  logic [BLOCK_WIDTH-1:0] off_nxt;
  logic [BLOCK_WIDTH-1:0] rd_idx;
  logic [DW-1:0]          rbuf_ins;

  // A strobe cycle is a bubble so the requester can drop or retarget its miss.
  assign any_stb  = d_vld_q | d_acc_q | i_vld_q;
  assign grant_ok = ~clearIn & ~any_stb;
  assign off_nxt  = cnt_q[BLOCK_WIDTH-1:0] + 1'b1;
  // The byte on memDin belongs to the address issued one count earlier.
  assign rd_idx   = cnt_q[BLOCK_WIDTH-1:0] - 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;   // 1 = ICache preferred on a tie

  // Tie-break toward the requester not served most recently.
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    rr_d  = rr_q;
    if (grant_ok) begin
      if (dMiss && iMiss) begin
        gnt_i = rr_q;
        gnt_d = ~rr_q;
      end else begin
        gnt_d = dMiss;
        gnt_i = iMiss;
      end
    end
    if (gnt_d) rr_d = 1'b1;
    if (gnt_i) rr_d = 1'b0;
  end

  // Round-robin pointer register, frozen while the system is stalled.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn)     rr_q <= 1'b0;
    else if (readyIn) rr_q <= rr_d;
  end
`else
  // Fixed priority: DCache always wins a tie.
  always_comb begin
    gnt_d = grant_ok & dMiss;
    gnt_i = grant_ok & iMiss & ~dMiss;
  end
`endif

  // Refill buffer with the byte arriving this cycle merged in.
  always_comb begin
    rbuf_ins = rbuf_q;
    rbuf_ins[{rd_idx, 3'b000} +: 8] = memDin;
  end

  // Transfer sequencer: next state, counter, buffers and registered RAM/cache outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    owner_d    = owner_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    d_vld_d    = d_vld_q;
    d_acc_d    = d_acc_q;
    i_vld_d    = i_vld_q;
    if (readyIn) begin
      d_vld_d = 1'b0;
      d_acc_d = 1'b0;
      i_vld_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          mem_wr_d = 1'b0;
          if (gnt_d || gnt_i) begin
            addr_d  = gnt_d ? dMissAddr : iMissAddr;
            owner_d = gnt_i;
            cnt_d   = '0;
            mem_a_d = {(gnt_d ? dMissAddr : iMissAddr), {BLOCK_WIDTH{1'b0}}};
            if (gnt_d && !dReadWrite) begin
              state_d    = S_WR;
              wbuf_d     = dWriteBack;
              mem_dout_d = dWriteBack[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d = S_RD;
            end
          end
        end
        S_RD: begin
          if (clearIn) begin
            state_d = S_IDLE;
          end else begin
            if (cnt_q != '0) rbuf_d = rbuf_ins;
            if (cnt_q == CNT_RD_DONE) begin
              mem_data_d = rbuf_ins;
              mem_addr_d = addr_q;
              d_vld_d    = ~owner_q;
              i_vld_d    = owner_q;
              state_d    = S_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
              // Last address stays on the bus while the final byte returns.
              if (cnt_q < CNT_WR_LAST) mem_a_d = {addr_q, off_nxt};
            end
          end
        end
        S_WR: begin
          if (cnt_q == CNT_WR_LAST) begin
            mem_wr_d   = 1'b0;
            mem_addr_d = addr_q;
            d_acc_d    = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            mem_a_d    = {addr_q, off_nxt};
            mem_dout_d = wbuf_q[{off_nxt, 3'b000} +: 8];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      owner_q    <= 1'b0;
      wbuf_q     <= '0;
      rbuf_q     <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      d_vld_q    <= 1'b0;
      d_acc_q    <= 1'b0;
      i_vld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      owner_q    <= owner_d;
      wbuf_q     <= wbuf_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      d_vld_q    <= d_vld_d;
      d_acc_q    <= d_acc_d;
      i_vld_q    <= i_vld_d;
    end
  end

  // A stall must never leave a write enable asserted on the RAM.
  assign memWr         = mem_wr_q & readyIn;
  assign memA          = mem_a_q;
  assign memDout       = mem_dout_q;
  assign memAddr       = mem_addr_q;
  assign memData       = mem_data_q;
  assign dMemDataValid = d_vld_q;
  assign dAcceptWrite  = d_acc_q;
  assign iMemDataValid = i_vld_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transfers plus hand sequences for
// arbitration, strobe bubble, stall, flush and asynchronous reset.
// RAM model returns the low byte of the byte address one enabled cycle later.
module tb_mem_arbiter;

  logic         clkIn;
  logic         resetIn, readyIn, clearIn;
  logic         dMiss, dReadWrite, iMiss;
  logic [27:0]  dMissAddr, iMissAddr;
  logic [127:0] dWriteBack;
  logic [7:0]   memDin, memDout;
  logic [31:0]  memA;
  logic         memWr;
  logic [27:0]  memAddr;
  logic [127:0] memData;
  logic         dMemDataValid, dAcceptWrite, iMemDataValid;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .dMiss(dMiss), .dMissAddr(dMissAddr), .dReadWrite(dReadWrite), .dWriteBack(dWriteBack),
    .iMiss(iMiss), .iMissAddr(iMissAddr), .memDin(memDin), .memDout(memDout),
    .memA(memA), .memWr(memWr), .memAddr(memAddr), .memData(memData),
    .dMemDataValid(dMemDataValid), .dAcceptWrite(dAcceptWrite), .iMemDataValid(iMemDataValid)
  );

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  // RAM shares the global enable, so a stalled read keeps its data.
  always @(posedge clkIn) if (readyIn) memDin <= memA[7:0];

  typedef struct {
    logic         is_i;
    logic         rd;
    logic [27:0]  addr;
    logic [127:0] wd;
    logic [127:0] exp_data;
    logic [2:0]   exp_stb;
    int           exp_lat;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [2:0] stbs();
    return {iMemDataValid, dAcceptWrite, dMemDataValid};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Samples each cycle after a grant edge until a strobe or the budget runs out.
  task automatic watch(input logic [27:0] base, input logic chk_a, input logic is_wr,
                       input logic [127:0] wd, output int lat, output logic [2:0] stb,
                       output int n_wr, output int a_err, output int d_err);
    lat = -1; stb = 3'b000; n_wr = 0; a_err = 0; d_err = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clkIn);
      if (memWr) n_wr++;
      if (chk_a && k < 16) begin
        if (memA !== {base, 4'(k)}) a_err++;
        if (is_wr && memDout !== wd[8*k +: 8]) d_err++;
      end
      if (stbs() != 3'b000) begin
        stb = stbs();
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, n_wr, a_err, d_err, s_err;
    logic [2:0] stb;
    logic second_i;

    vecs[0] = '{1'b0, 1'b1, 28'h0000123, 128'h0,
                128'h3f3e3d3c3b3a39383736353433323130, 3'b001, 17};
    vecs[1] = '{1'b0, 1'b0, 28'h0000200, 128'h00112233445566778899aabbccddeeff,
                128'h3f3e3d3c3b3a39383736353433323130, 3'b010, 16};
    vecs[2] = '{1'b1, 1'b1, 28'h00abcde, 128'h0,
                128'hefeeedecebeae9e8e7e6e5e4e3e2e1e0, 3'b100, 17};
    vecs[3] = '{1'b0, 1'b1, 28'hfffffff, 128'h0,
                128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, 3'b001, 17};
    vecs[4] = '{1'b0, 1'b0, 28'h0000001, 128'h0123456789abcdeffedcba9876543210,
                128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, 3'b010, 16};

    resetIn = 1'b0; readyIn = 1'b1; clearIn = 1'b0;
    dMiss = 1'b0; dReadWrite = 1'b1; dMissAddr = '0; dWriteBack = '0;
    iMiss = 1'b0; iMissAddr = '0;

    // Reset state
    repeat (3) @(negedge clkIn);
    check("rst_memA", 128'(memA), 128'h0);
    check("rst_memDout", 128'(memDout), 128'h0);
    check("rst_memWr", 128'(memWr), 128'h0);
    check("rst_memAddr", 128'(memAddr), 128'h0);
    check("rst_memData", memData, 128'h0);
    check("rst_strobes", 128'(stbs()), 128'h0);
    resetIn = 1'b1;

    // Table of single-requester transfers
    for (int n = 0; n < 5; n++) begin
      @(posedge clkIn); #1;
      if (vecs[n].is_i) begin
        iMiss = 1'b1; iMissAddr = vecs[n].addr;
      end else begin
        dMiss = 1'b1; dMissAddr = vecs[n].addr;
        dReadWrite = vecs[n].rd; dWriteBack = vecs[n].wd;
      end
      @(posedge clkIn); #1;
      iMiss = 1'b0; dMiss = 1'b0;
      watch(vecs[n].addr, 1'b1, ~vecs[n].rd, vecs[n].wd, lat, stb, n_wr, a_err, d_err);
      check($sformatf("vec%0d_latency", n), 128'(lat), 128'(vecs[n].exp_lat));
      check($sformatf("vec%0d_strobe", n), 128'(stb), 128'(vecs[n].exp_stb));
      check($sformatf("vec%0d_memA_errs", n), 128'(a_err), 128'h0);
      check($sformatf("vec%0d_memDout_errs", n), 128'(d_err), 128'h0);
      check($sformatf("vec%0d_write_cycles", n), 128'(n_wr), vecs[n].rd ? 128'd0 : 128'd16);
      check($sformatf("vec%0d_memAddr", n), 128'(memAddr), 128'(vecs[n].addr));
      check($sformatf("vec%0d_memData", n), memData, vecs[n].exp_data);
      @(negedge clkIn);
      check($sformatf("vec%0d_strobe_width", n), 128'(stbs()), 128'h0);
    end

    // Asynchronous reset in the middle of a write-back
    @(posedge clkIn); #1;
    dMiss = 1'b1; dReadWrite = 1'b0; dMissAddr = 28'h0000400; dWriteBack = vecs[1].wd;
    @(posedge clkIn); #1;
    dMiss = 1'b0;
    repeat (5) @(posedge clkIn);
    #2 check("midwr_memWr_before", 128'(memWr), 128'h1);
    #1 resetIn = 1'b0;
    #1;
    check("midwr_rst_memWr", 128'(memWr), 128'h0);
    check("midwr_rst_memA", 128'(memA), 128'h0);
    check("midwr_rst_memDout", 128'(memDout), 128'h0);
    check("midwr_rst_memAddr", 128'(memAddr), 128'h0);
    check("midwr_rst_memData", memData, 128'h0);
    check("midwr_rst_strobes", 128'(stbs()), 128'h0);
    #2 resetIn = 1'b1;

    // Simultaneous misses, two rounds
`ifdef ARB_ROUND_ROBIN_EN
    second_i = 1'b1;
`else
    second_i = 1'b0;
`endif
    for (int r = 0; r < 2; r++) begin
      logic exp_i;
      exp_i = (r == 1) ? second_i : 1'b0;
      @(posedge clkIn); #1;
      dMiss = 1'b1; dReadWrite = 1'b1; dMissAddr = 28'h0000010;
      iMiss = 1'b1; iMissAddr = 28'h0000020;
      @(posedge clkIn); #1;
      dMiss = 1'b0; iMiss = 1'b0;
      watch(exp_i ? 28'h0000020 : 28'h0000010, 1'b1, 1'b0, 128'h0, lat, stb, n_wr, a_err, d_err);
      check($sformatf("arb%0d_memA_errs", r), 128'(a_err), 128'h0);
      check($sformatf("arb%0d_strobe", r), 128'(stb), exp_i ? 128'h4 : 128'h1);
      check($sformatf("arb%0d_memAddr", r), 128'(memAddr), exp_i ? 128'h20 : 128'h10);
    end

    // Request raised during the strobe cycle waits one extra cycle
    dMiss = 1'b1; dReadWrite = 1'b1; dMissAddr = 28'h0000060;
    @(posedge clkIn);
    @(posedge clkIn); #1;
    dMiss = 1'b0;
    watch(28'h0000060, 1'b1, 1'b0, 128'h0, lat, stb, n_wr, a_err, d_err);
    check("bubble_memA_errs", 128'(a_err), 128'h0);
    check("bubble_latency", 128'(lat), 128'd17);

    // Five-cycle stall in the middle of a refill
    @(posedge clkIn); #1;
    dMiss = 1'b1; dReadWrite = 1'b1; dMissAddr = 28'h0000123;
    @(posedge clkIn); #1;
    dMiss = 1'b0;
    repeat (5) @(posedge clkIn);
    @(posedge clkIn); #1;
    readyIn = 1'b0;
    s_err = 0;
    repeat (5) begin
      @(negedge clkIn);
      if (memA !== 32'h00001236 || memWr !== 1'b0) s_err++;
      @(posedge clkIn);
    end
    #1 readyIn = 1'b1;
    watch(28'h0, 1'b0, 1'b0, 128'h0, lat, stb, n_wr, a_err, d_err);
    check("stall_frozen_errs", 128'(s_err), 128'h0);
    check("stall_latency", 128'(lat + 11), 128'd22);
    check("stall_strobe", 128'(stb), 128'h1);
    check("stall_memData", memData, vecs[0].exp_data);

    // Flush during an ICache refill, then a DCache refill granted right after
    @(posedge clkIn); #1;
    iMiss = 1'b1; iMissAddr = 28'h0000040;
    @(posedge clkIn); #1;
    iMiss = 1'b0;
    repeat (9) @(posedge clkIn);
    #1 clearIn = 1'b1;
    @(posedge clkIn); #1;
    clearIn = 1'b0;
    dMiss = 1'b1; dReadWrite = 1'b1; dMissAddr = 28'h0000050;
    @(posedge clkIn); #1;
    dMiss = 1'b0;
    watch(28'h0000050, 1'b1, 1'b0, 128'h0, lat, stb, n_wr, a_err, d_err);
    check("clr_rd_strobe", 128'(stb), 128'h1);
    check("clr_rd_next_memA_errs", 128'(a_err), 128'h0);
    check("clr_rd_next_latency", 128'(lat), 128'd17);
    check("clr_rd_memAddr", 128'(memAddr), 128'h50);

    // Flush during a write-back has no effect
    @(posedge clkIn); #1;
    dMiss = 1'b1; dReadWrite = 1'b0; dMissAddr = 28'h0000300; dWriteBack = vecs[1].wd;
    @(posedge clkIn); #1;
    dMiss = 1'b0;
    fork
      begin
        repeat (9) @(posedge clkIn);
        #1 clearIn = 1'b1;
        @(posedge clkIn);
        #1 clearIn = 1'b0;
      end
    join_none
    watch(28'h0000300, 1'b1, 1'b1, vecs[1].wd, lat, stb, n_wr, a_err, d_err);
    check("clr_wr_latency", 128'(lat), 128'd16);
    check("clr_wr_strobe", 128'(stb), 128'h2);
    check("clr_wr_write_cycles", 128'(n_wr), 128'd16);
    check("clr_wr_memA_errs", 128'(a_err), 128'h0);
    check("clr_wr_memDout_errs", 128'(d_err), 128'h0);

    repeat (3) @(posedge clkIn);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
